// File: rtl/vending_txn_controller_if.sv
// Signal bundle between the vending transaction controller and its surroundings:
// button/coin pulses in, dispenser handshake and display values out.
`timescale 1ns/1ps
interface vending_txn_controller_if #(
  parameter int MONEY_W   = 10,
  parameter int PRICE_W   = 5,
  parameter int QTY_W     = 2,
  parameter int MAX_ITEMS = 4
);
  localparam int CNT_W = $clog2(MAX_ITEMS + 1);

  logic               item_valid;
  logic [PRICE_W-1:0] item_price;
  logic [QTY_W-1:0]   item_qty;
  logic               sys_Confirm;
  logic               sys_Cancel;
  logic               coin_valid;
  logic [2:0]         coin_code;
  logic               chg_ready;
  logic               chg_valid;
  logic [2:0]         chg_code;
  logic               coin_reject;
  logic               vend_valid;
  logic               refund_o;
  logic [2:0]         state_o;
  logic [MONEY_W-1:0] need_money;
  logic [MONEY_W-1:0] paid_money;
  logic [MONEY_W-1:0] change_money;
  logic [CNT_W-1:0]   item_count;

  modport master (
    output item_valid, item_price, item_qty, sys_Confirm, sys_Cancel,
           coin_valid, coin_code, chg_ready,
    input  chg_valid, chg_code, coin_reject, vend_valid, refund_o, state_o,
           need_money, paid_money, change_money, item_count
  );

  modport slave (
    input  item_valid, item_price, item_qty, sys_Confirm, sys_Cancel,
           coin_valid, coin_code, chg_ready,
    output chg_valid, chg_code, coin_reject, vend_valid, refund_o, state_o,
           need_money, paid_money, change_money, item_count
  );
endinterface

// File: rtl/vending_txn_controller.sv
// Cart/payment/vend/change FSM for the micro vending machine; change and refunds
// are paid out greedily, one coin per valid/ready handshake.
`timescale 1ns/1ps
module vending_txn_controller #(
  parameter int MONEY_W     = 10,
  parameter int PRICE_W     = 5,
  parameter int QTY_W       = 2,
  parameter int MAX_ITEMS   = 4,
  parameter int TIMEOUT_CYC = 1000
) (
  input logic                     sys_clk,
  input logic                     sys_rst,
  vending_txn_controller_if.slave bus
);
  localparam int CNT_W  = $clog2(MAX_ITEMS + 1);
  localparam int PROD_W = PRICE_W + QTY_W;
  localparam int SUM_W  = MONEY_W + 1;
  localparam int TMR_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_PAY    = 3'd2,
    S_VEND   = 3'd3,
    S_CHANGE = 3'd4
  } state_t;

  state_t           state;
  logic [TMR_W-1:0] timer;

  logic [PROD_W-1:0]  item_prod;
  logic [SUM_W-1:0]   need_sum;
  logic [SUM_W-1:0]   paid_sum;
  logic [MONEY_W-1:0] paid_next;
  logic [MONEY_W-1:0] vend_diff;
  logic [MONEY_W-1:0] chg_left;
  logic               item_ok;
  logic               coin_ok;
  logic               pay_exit;

  function automatic logic [MONEY_W-1:0] coin_value(input logic [2:0] code);
    case (code)
      3'd0:    coin_value = MONEY_W'(1);
      3'd1:    coin_value = MONEY_W'(5);
      3'd2:    coin_value = MONEY_W'(10);
      3'd3:    coin_value = MONEY_W'(20);
      3'd4:    coin_value = MONEY_W'(50);
      default: coin_value = '0;
    endcase
  endfunction

  // Largest denomination not exceeding the amount still owed.
  function automatic logic [2:0] greedy_code(input logic [MONEY_W-1:0] amt);
    if (amt >= MONEY_W'(50))      greedy_code = 3'd4;
    else if (amt >= MONEY_W'(20)) greedy_code = 3'd3;
    else if (amt >= MONEY_W'(10)) greedy_code = 3'd2;
    else if (amt >= MONEY_W'(5))  greedy_code = 3'd1;
    else                          greedy_code = 3'd0;
  endfunction

  always_comb begin
    item_prod = PROD_W'(bus.item_price) * PROD_W'(bus.item_qty);
    need_sum  = {1'b0, bus.need_money} + SUM_W'(item_prod);
    item_ok   = bus.item_valid && (bus.item_qty != '0) &&
                (bus.item_count < CNT_W'(MAX_ITEMS)) && !need_sum[MONEY_W];
    paid_sum  = {1'b0, bus.paid_money} + {1'b0, coin_value(bus.coin_code)};
    coin_ok   = bus.coin_valid && (bus.coin_code <= 3'd4) && !paid_sum[MONEY_W];
    paid_next = coin_ok ? paid_sum[MONEY_W-1:0] : bus.paid_money;
    // A coin arriving on the timeout cycle restarts the idle window instead.
    pay_exit  = bus.sys_Cancel || (!bus.coin_valid && (timer == TMR_W'(TIMEOUT_CYC - 1)));
    vend_diff = bus.paid_money - bus.need_money;
    chg_left  = bus.change_money - coin_value(bus.chg_code);
  end

  assign bus.state_o = state;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state            <= S_IDLE;
      timer            <= '0;
      bus.need_money   <= '0;
      bus.paid_money   <= '0;
      bus.change_money <= '0;
      bus.item_count   <= '0;
      bus.chg_valid    <= 1'b0;
      bus.chg_code     <= 3'd0;
      bus.coin_reject  <= 1'b0;
      bus.vend_valid   <= 1'b0;
      bus.refund_o     <= 1'b0;
    end else begin
      bus.vend_valid  <= 1'b0;
      bus.coin_reject <= 1'b0;
      case (state)
        S_IDLE: begin
          bus.coin_reject <= bus.coin_valid;
          if (bus.sys_Confirm) begin
            state            <= S_SELECT;
            bus.need_money   <= '0;
            bus.paid_money   <= '0;
            bus.change_money <= '0;
            bus.item_count   <= '0;
          end
        end
        S_SELECT: begin
          bus.coin_reject <= bus.coin_valid;
          if (item_ok) begin
            bus.need_money <= need_sum[MONEY_W-1:0];
            bus.item_count <= bus.item_count + 1'b1;
          end
          if (bus.sys_Cancel) begin
            state <= S_IDLE;
          end else if (bus.sys_Confirm && (item_ok || (bus.item_count != '0))) begin
            state <= S_PAY;
            timer <= '0;
          end
        end
        S_PAY: begin
          bus.coin_reject <= bus.coin_valid && !coin_ok;
          bus.paid_money  <= paid_next;
          timer           <= bus.coin_valid ? '0 : timer + 1'b1;
          if (pay_exit) begin
            if (paid_next == '0) begin
              state <= S_IDLE;
            end else begin
              state            <= S_CHANGE;
              bus.change_money <= paid_next;
              bus.chg_valid    <= 1'b1;
              bus.chg_code     <= greedy_code(paid_next);
              bus.refund_o     <= 1'b1;
            end
          end else if (bus.paid_money >= bus.need_money) begin
            state          <= S_VEND;
            bus.vend_valid <= 1'b1;
          end
        end
        S_VEND: begin
          bus.coin_reject  <= bus.coin_valid;
          bus.change_money <= vend_diff;
          bus.chg_valid    <= (vend_diff != '0);
          bus.chg_code     <= greedy_code(vend_diff);
          state            <= (vend_diff != '0) ? S_CHANGE : S_IDLE;
        end
        S_CHANGE: begin
          bus.coin_reject <= bus.coin_valid;
          if (bus.chg_valid && bus.chg_ready) begin
            bus.change_money <= chg_left;
            bus.chg_valid    <= (chg_left != '0);
            bus.chg_code     <= greedy_code(chg_left);
            if (chg_left == '0) begin
              state        <= S_IDLE;
              bus.refund_o <= 1'b0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vending_txn_controller.sv
// Directed bench for vending_txn_controller: a cycle-by-cycle vector table plus
// hand-written sequences for stalled change, timeouts and reset during payout.
`timescale 1ns/1ps
module tb_vending_txn_controller;
  typedef struct packed {
    logic [2:0] st;
    logic [9:0] need;
    logic [9:0] paid;
    logic [9:0] chg;
    logic [2:0] cnt;
    logic       cv;
    logic [2:0] code;
    logic       rej;
    logic       vend;
    logic       rf;
  } out_t;

  typedef struct {
    string      nm;
    logic       rst;
    logic       iv;
    logic [4:0] pr;
    logic [1:0] q;
    logic       cf;
    logic       cn;
    logic       cv;
    logic [2:0] cc;
    logic       rdy;
    out_t       exp;
  } vec_t;

  logic sys_clk = 1'b0;
  logic sys_rst;
  int   n_vec  = 0;
  int   n_miss = 0;
  vec_t vecs[$];

  vending_txn_controller_if #(.MONEY_W(10), .PRICE_W(5), .QTY_W(2), .MAX_ITEMS(4)) bus ();

  vending_txn_controller #(
    .MONEY_W(10), .PRICE_W(5), .QTY_W(2), .MAX_ITEMS(4), .TIMEOUT_CYC(16)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic vec_t mk(string nm, logic rst, logic iv, logic [4:0] pr, logic [1:0] q,
                              logic cf, logic cn, logic cv, logic [2:0] cc, logic rdy,
                              logic [2:0] st, int need, int paid, int chg, int cnt,
                              logic vld, logic [2:0] code, logic rej, logic vend, logic rf);
    vec_t v;
    v.nm = nm; v.rst = rst; v.iv = iv; v.pr = pr; v.q = q; v.cf = cf; v.cn = cn;
    v.cv = cv; v.cc = cc; v.rdy = rdy;
    v.exp = '{st: st, need: 10'(need), paid: 10'(paid), chg: 10'(chg), cnt: 3'(cnt),
              cv: vld, code: code, rej: rej, vend: vend, rf: rf};
    return v;
  endfunction

  function automatic out_t sample();
    out_t o;
    o = '{st: bus.state_o, need: bus.need_money, paid: bus.paid_money, chg: bus.change_money,
          cnt: bus.item_count, cv: bus.chg_valid, code: bus.chg_code, rej: bus.coin_reject,
          vend: bus.vend_valid, rf: bus.refund_o};
    return o;
  endfunction

  function automatic string fmt(out_t o);
    return $sformatf("st=%0d need=%0d paid=%0d chg=%0d cnt=%0d cv=%0d code=%0d rej=%0d vend=%0d rf=%0d",
                     o.st, o.need, o.paid, o.chg, o.cnt, o.cv, o.code, o.rej, o.vend, o.rf);
  endfunction

  function automatic int denom(logic [2:0] code);
    int tbl[5] = '{1, 5, 10, 20, 50};
    return (code <= 3'd4) ? tbl[code] : 0;
  endfunction

  task automatic chk(string nm, int got, int exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0; bus.item_valid = 1'b0; bus.sys_Confirm = 1'b0; bus.sys_Cancel = 1'b0;
    bus.coin_valid = 1'b0;
  endtask

  // Opens a one-item cart of the given price, confirms it and inserts one coin.
  task automatic open_pay(input logic [4:0] price, input logic coin, input logic [2:0] code);
    bus.sys_Confirm = 1'b1; tick();
    bus.item_valid = 1'b1; bus.item_price = price; bus.item_qty = 2'd1; bus.sys_Confirm = 1'b1; tick();
    if (coin) begin
      bus.coin_valid = 1'b1; bus.coin_code = code; tick();
    end
  endtask

  initial begin
    int   n;
    int   total;
    logic pv;
    logic [2:0] pc;
    int   codes[$];
    int   exp_codes[5] = '{20, 20, 1, 1, 1};
    out_t got;

    sys_rst = 1'b1;
    bus.item_valid = 1'b0; bus.item_price = '0; bus.item_qty = '0; bus.sys_Confirm = 1'b0;
    bus.sys_Cancel = 1'b0; bus.coin_valid = 1'b0; bus.coin_code = '0; bus.chg_ready = 1'b0;

    //                 name            rst iv pr  q  cf cn cv cc rdy   st need paid chg cnt cv code rej vend rf
    vecs.push_back(mk("reset",          1, 0, 0, 0, 1, 0, 0, 0, 0,    0,  0,   0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("idle_coin",      0, 0, 0, 0, 0, 0, 1, 2, 0,    0,  0,   0,  0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk("idle_quiet",     0, 0, 0, 0, 0, 0, 0, 0, 0,    0,  0,   0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("to_select",      0, 0, 0, 0, 1, 0, 0, 0, 0,    1,  0,   0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("empty_confirm",  0, 0, 0, 0, 1, 0, 0, 0, 0,    1,  0,   0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("select_coin",    0, 0, 0, 0, 0, 0, 1, 0, 0,    1,  0,   0,  0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk("item_3x2",       0, 1, 3, 2, 0, 0, 0, 0, 0,    1,  6,   0,  0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("item_qty0",      0, 1, 9, 0, 0, 0, 0, 0, 0,    1,  6,   0,  0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("item_10x1",      0, 1,10, 1, 0, 0, 0, 0, 0,    1, 16,   0,  0, 2, 0, 0, 0, 0, 0));
    vecs.push_back(mk("to_pay",         0, 0, 0, 0, 1, 0, 0, 0, 0,    2, 16,   0,  0, 2, 0, 0, 0, 0, 0));
    vecs.push_back(mk("coin_10",        0, 0, 0, 0, 0, 0, 1, 2, 0,    2, 16,  10,  0, 2, 0, 0, 0, 0, 0));
    vecs.push_back(mk("coin_5",         0, 0, 0, 0, 0, 0, 1, 1, 0,    2, 16,  15,  0, 2, 0, 0, 0, 0, 0));
    vecs.push_back(mk("short_no_vend",  0, 0, 0, 0, 0, 0, 0, 0, 0,    2, 16,  15,  0, 2, 0, 0, 0, 0, 0));
    vecs.push_back(mk("bad_code_6",     0, 0, 0, 0, 0, 0, 1, 6, 0,    2, 16,  15,  0, 2, 0, 0, 1, 0, 0));
    vecs.push_back(mk("coin_1",         0, 0, 0, 0, 0, 0, 1, 0, 0,    2, 16,  16,  0, 2, 0, 0, 0, 0, 0));
    vecs.push_back(mk("vend_pulse",     0, 0, 0, 0, 0, 0, 0, 0, 0,    3, 16,  16,  0, 2, 0, 0, 0, 1, 0));
    vecs.push_back(mk("exact_to_idle",  0, 0, 0, 0, 0, 0, 0, 0, 0,    0, 16,  16,  0, 2, 0, 0, 0, 0, 0));
    vecs.push_back(mk("idle_hold",      0, 0, 0, 0, 0, 0, 0, 0, 0,    0, 16,  16,  0, 2, 0, 0, 0, 0, 0));
    vecs.push_back(mk("new_cart",       0, 0, 0, 0, 1, 0, 0, 0, 0,    1,  0,   0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("fill_1",         0, 1, 1, 1, 0, 0, 0, 0, 0,    1,  1,   0,  0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("fill_2",         0, 1, 1, 1, 0, 0, 0, 0, 0,    1,  2,   0,  0, 2, 0, 0, 0, 0, 0));
    vecs.push_back(mk("fill_3",         0, 1, 1, 1, 0, 0, 0, 0, 0,    1,  3,   0,  0, 3, 0, 0, 0, 0, 0));
    vecs.push_back(mk("fill_4",         0, 1, 1, 1, 0, 0, 0, 0, 0,    1,  4,   0,  0, 4, 0, 0, 0, 0, 0));
    vecs.push_back(mk("fifth_item",     0, 1, 5, 3, 0, 0, 0, 0, 0,    1,  4,   0,  0, 4, 0, 0, 0, 0, 0));
    vecs.push_back(mk("cancel_vs_conf", 0, 0, 0, 0, 1, 1, 0, 0, 0,    0,  4,   0,  0, 4, 0, 0, 0, 0, 0));
    vecs.push_back(mk("refund_cart",    0, 0, 0, 0, 1, 0, 0, 0, 0,    1,  0,   0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("item_and_conf",  0, 1,31, 3, 1, 0, 0, 0, 0,    2, 93,   0,  0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("pay_20",         0, 0, 0, 0, 0, 0, 1, 3, 0,    2, 93,  20,  0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("pay_5",          0, 0, 0, 0, 0, 0, 1, 1, 0,    2, 93,  25,  0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("cancel_coin",    0, 0, 0, 0, 0, 1, 1, 1, 0,    4, 93,  30, 30, 1, 1, 3, 0, 0, 1));
    vecs.push_back(mk("refund_20",      0, 0, 0, 0, 1, 0, 1, 4, 1,    4, 93,  30, 10, 1, 1, 2, 1, 0, 1));
    vecs.push_back(mk("refund_10",      0, 0, 0, 0, 0, 0, 0, 0, 1,    0, 93,  30,  0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("cart_43",        0, 0, 0, 0, 1, 0, 0, 0, 0,    1,  0,   0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("item7_conf",     0, 1, 7, 1, 1, 0, 0, 0, 0,    2,  7,   0,  0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("coin_50",        0, 0, 0, 0, 0, 0, 1, 4, 0,    2,  7,  50,  0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("vend_43",        0, 0, 0, 0, 0, 0, 0, 0, 0,    3,  7,  50,  0, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk("change_enter",   0, 0, 0, 0, 0, 0, 0, 0, 1,    4,  7,  50, 43, 1, 1, 3, 0, 0, 0));
    vecs.push_back(mk("chg_20a",        0, 0, 0, 0, 0, 0, 0, 0, 1,    4,  7,  50, 23, 1, 1, 3, 0, 0, 0));
    vecs.push_back(mk("chg_20b",        0, 0, 0, 0, 0, 0, 0, 0, 1,    4,  7,  50,  3, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk("chg_1a",         0, 0, 0, 0, 0, 0, 0, 0, 1,    4,  7,  50,  2, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk("chg_1b",         0, 0, 0, 0, 0, 0, 0, 0, 1,    4,  7,  50,  1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk("chg_1c",         0, 0, 0, 0, 0, 0, 0, 0, 1,    0,  7,  50,  0, 1, 0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      sys_rst = vecs[i].rst; bus.item_valid = vecs[i].iv; bus.item_price = vecs[i].pr;
      bus.item_qty = vecs[i].q; bus.sys_Confirm = vecs[i].cf; bus.sys_Cancel = vecs[i].cn;
      bus.coin_valid = vecs[i].cv; bus.coin_code = vecs[i].cc; bus.chg_ready = vecs[i].rdy;
      tick();
      got = sample();
      n_vec++;
      if (got !== vecs[i].exp) begin
        n_miss++;
        $display("FAIL %s: got %s | expected %s", vecs[i].nm, fmt(got), fmt(vecs[i].exp));
      end
    end
    bus.chg_ready = 1'b0;

    // 43 change with the dispenser stalling three cycles out of every six.
    open_pay(5'd7, 1'b1, 3'd4);
    n = 0;
    while (bus.state_o != 3'd4 && n < 8) begin tick(); n++; end
    chk("stall_reach_change", bus.state_o, 4);
    total = 0;
    for (int c = 0; c < 200 && bus.state_o == 3'd4; c++) begin
      bus.chg_ready = ((c / 3) % 2) == 1;
      pv = bus.chg_valid; pc = bus.chg_code;
      tick();
      if (pv && !bus.chg_ready) begin
        chk("stall_code_hold", bus.chg_code, pc);
        chk("stall_valid_hold", bus.chg_valid, 1);
      end
      if (pv && bus.chg_ready) begin
        total += denom(pc);
        codes.push_back(denom(pc));
      end
    end
    bus.chg_ready = 1'b0;
    chk("stall_end_idle", bus.state_o, 0);
    chk("stall_total", total, 43);
    chk("stall_coin_count", codes.size(), 5);
    foreach (exp_codes[k]) chk($sformatf("stall_coin_%0d", k), (k < codes.size()) ? codes[k] : -1, exp_codes[k]);

    // Timeout with 1 paid: sixteen idle cycles after the coin, then a single 1 refunded.
    open_pay(5'd5, 1'b1, 3'd0);
    n = 0;
    while (bus.state_o == 3'd2 && n < 40) begin tick(); n++; end
    chk("tmo1_cycles", n, 16);
    got = sample();
    chk("tmo1_state", got.st, 4);
    chk("tmo1_refund", got.rf, 1);
    chk("tmo1_change", got.chg, 1);
    chk("tmo1_code", got.code, 0);
    chk("tmo1_valid", got.cv, 1);
    bus.chg_ready = 1'b1; tick(); bus.chg_ready = 1'b0;
    chk("tmo1_done_state", bus.state_o, 0);
    chk("tmo1_done_refund", bus.refund_o, 0);

    // Timeout with nothing paid goes straight back to IDLE.
    open_pay(5'd5, 1'b0, 3'd0);
    n = 0;
    while (bus.state_o == 3'd2 && n < 40) begin tick(); n++; end
    chk("tmo0_cycles", n, 16);
    chk("tmo0_state", bus.state_o, 0);
    chk("tmo0_no_chg", bus.chg_valid, 0);

    // Reset while change is still owed.
    open_pay(5'd7, 1'b1, 3'd4);
    tick(); tick();
    chk("rst_mid_state", bus.state_o, 4);
    sys_rst = 1'b1; tick();
    chk("rst_mid_outputs", sample(), 0);
    tick();
    chk("rst_after_outputs", sample(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000 ns");
    $fatal(1, "watchdog");
  end
endmodule
